// File: rtl/bfly_feeder.sv
`default_nettype none
// bfly_feeder: presents twiddle/operand words on sw, one ReadyIn strobe per step, and collects butterfly results.
// Result capture is built only when BFLY_FEEDER_CAPTURE_EN is defined; otherwise the result outputs are tied to zero.
module bfly_feeder #(
  parameter int n        = 8,
  parameter int HIGH_CYC = 1,
  parameter int LOW_CYC  = 2
) (
  input  logic         clk,
  input  logic         Rst,
  input  logic [n-1:0] Rew_i,
  input  logic [n-1:0] Imw_i,
  input  logic [n-1:0] Reb_i,
  input  logic [n-1:0] Imb_i,
  input  logic [n-1:0] Rea_i,
  input  logic [n-1:0] Ima_i,
  input  logic         start,
  output logic         ReadyIn,
  output logic [n-1:0] sw,
  input  logic [n-1:0] res_in,
  output logic [n-1:0] Rey_o,
  output logic [n-1:0] Imy_o,
  output logic [n-1:0] Rez_o,
  output logic [n-1:0] Imz_o,
  output logic         busy,
  output logic         done,
  output logic         w_loaded
);

  localparam int            CMAX      = (HIGH_CYC > LOW_CYC) ? HIGH_CYC : LOW_CYC;
  localparam int            CW        = $clog2(CMAX + 1);
  localparam logic [CW-1:0] HI_LAST   = CW'(HIGH_CYC - 1);
  localparam logic [CW-1:0] LO_LAST   = CW'(LOW_CYC - 1);
  localparam logic [3:0]    STEP_LAST = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_HI   = 2'd1,
    S_LO   = 2'd2,
    S_FIN  = 2'd3
  } state_t;

  state_t        state_q;
  logic [3:0]    step_q;
  logic [3:0]    step_d;
  logic [3:0]    sel_idx;
  logic [CW-1:0] cyc_q;
  logic [n-1:0]  rew_q, imw_q, reb_q, imb_q, rea_q, ima_q;
  logic [n-1:0]  sw_q;
  logic [n-1:0]  sw_d;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
  logic          wl_q;
  logic          lo_end;

  assign lo_end  = (state_q == S_LO) && (cyc_q == LO_LAST);
  assign step_d  = step_q + 4'd1;
  // Entering HI from IDLE uses the freshly loaded index; from LO it is the following step.
  assign sel_idx = (state_q == S_LO) ? step_d : step_q;

  always_comb begin
    sw_d = '0;
    case (sel_idx)
      4'd0:    sw_d = rew_q;
      4'd1:    sw_d = imw_q;
      4'd2:    sw_d = reb_q;
      4'd3:    sw_d = imb_q;
      4'd4:    sw_d = rea_q;
      4'd5:    sw_d = ima_q;
      default: sw_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (Rst) begin
      state_q <= S_IDLE;
      step_q  <= 4'd0;
      cyc_q   <= '0;
      rew_q   <= '0;
      imw_q   <= '0;
      reb_q   <= '0;
      imb_q   <= '0;
      rea_q   <= '0;
      ima_q   <= '0;
      sw_q    <= '0;
      ready_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wl_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (busy_q) begin
            state_q <= S_HI;
            ready_q <= 1'b1;
            sw_q    <= sw_d;
            cyc_q   <= '0;
          end else if (start) begin
            rew_q  <= Rew_i;
            imw_q  <= Imw_i;
            reb_q  <= Reb_i;
            imb_q  <= Imb_i;
            rea_q  <= Rea_i;
            ima_q  <= Ima_i;
            busy_q <= 1'b1;
            step_q <= wl_q ? 4'd2 : 4'd0;
          end
        end
        S_HI: begin
          if (cyc_q == HI_LAST) begin
            state_q <= S_LO;
            ready_q <= 1'b0;
            cyc_q   <= '0;
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        S_LO: begin
          if (lo_end) begin
            if (step_q == 4'd1) begin
              wl_q <= 1'b1;
            end
            if (step_q == STEP_LAST) begin
              state_q <= S_FIN;
              sw_q    <= '0;
            end else begin
              step_q  <= step_d;
              state_q <= S_HI;
              ready_q <= 1'b1;
              sw_q    <= sw_d;
              cyc_q   <= '0;
            end
          end else begin
            cyc_q <= cyc_q + CW'(1);
          end
        end
        S_FIN: begin
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign ReadyIn  = ready_q;
  assign sw       = sw_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign w_loaded = wl_q;

`ifdef BFLY_FEEDER_CAPTURE_EN
  logic [n-1:0] rey_q, imy_q, rez_q, imz_q;

  // Results are sampled at the close of the step whose output the datapath is displaying.
  always_ff @(posedge clk) begin
    if (Rst) begin
      rey_q <= '0;
      imy_q <= '0;
      rez_q <= '0;
      imz_q <= '0;
    end else if (lo_end) begin
      case (step_q)
        4'd5:    rey_q <= res_in;
        4'd6:    imy_q <= res_in;
        4'd7:    rez_q <= res_in;
        4'd8:    imz_q <= res_in;
        default: ;
      endcase
    end
  end

  assign Rey_o = rey_q;
  assign Imy_o = imy_q;
  assign Rez_o = rez_q;
  assign Imz_o = imz_q;
`else
  logic unused_res_in;
  assign unused_res_in = ^res_in;

  assign Rey_o = '0;
  assign Imy_o = '0;
  assign Rez_o = '0;
  assign Imz_o = '0;
`endif

endmodule
`default_nettype wire
